// File: rtl/prio_index_decoder_if.sv
// Handshake bundle for prio_index_decoder: index stream in, decoded code out,
// plus the sticky pending/clear/error side channel.
interface prio_index_decoder_if #(
  parameter int IDX_W   = 3,
  parameter int NUM_OUT = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [IDX_W-1:0]   in_idx;
  logic               out_valid;
  logic               out_ready;
  logic [NUM_OUT-1:0] out_code;
  logic [NUM_OUT-1:0] pending;
  logic [NUM_OUT-1:0] clr_mask;
  logic               err;

  modport slave (
    input  in_valid, in_idx, out_ready, clr_mask,
    output in_ready, out_valid, out_code, pending, err
  );

  modport master (
    output in_valid, in_idx, out_ready, clr_mask,
    input  in_ready, out_valid, out_code, pending, err
  );
endinterface

// File: rtl/prio_index_decoder.sv
// Index-to-code decoder behind a two-entry elastic buffer (OREG + SREG) with a
// sticky W1C pending mask. Define PRIO_DEC_THERMO_EN for thermometer out_code.
module prio_index_decoder #(
  parameter int IDX_W   = 3,
  parameter int NUM_OUT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  prio_index_decoder_if.slave  bus
);

  if (NUM_OUT < 2 || NUM_OUT > (1 << IDX_W)) begin : g_bad_num_out
    $error("prio_index_decoder: NUM_OUT must lie in 2..2**IDX_W");
  end

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam logic [IDX_W:0] NUM_OUT_L = (IDX_W + 1)'(NUM_OUT);

  function automatic logic [NUM_OUT-1:0] decode_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_OUT-1:0] c;
    c = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      c[k] = (idx == IDX_W'(k));
    end
    return c;
  endfunction

  function automatic logic [NUM_OUT-1:0] decode_thermo(input logic [IDX_W-1:0] idx);
    logic [NUM_OUT-1:0] c;
    c = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      c[k] = (IDX_W'(k) <= idx);
    end
    return c;
  endfunction

  state_e             state_q, state_d;
  logic [NUM_OUT-1:0] oreg_q, oreg_d;
  logic [NUM_OUT-1:0] sreg_q, sreg_d;
  logic [NUM_OUT-1:0] pending_q, pending_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               err_q, err_d;

  logic               acc_s, in_range_s, push_s, pop_s;
  logic [NUM_OUT-1:0] hot_s, code_s;

  assign acc_s      = bus.in_valid & in_ready_q;
  assign in_range_s = ({1'b0, bus.in_idx} < NUM_OUT_L);
  assign push_s     = acc_s & in_range_s;
  assign pop_s      = out_valid_q & bus.out_ready;
  assign hot_s      = decode_onehot(bus.in_idx);

`ifdef PRIO_DEC_THERMO_EN
  assign code_s = decode_thermo(bus.in_idx);
`else
  assign code_s = hot_s;
`endif

  // Buffer FSM: next state, OREG/SREG loads, and the side-channel next values.
  always_comb begin
    state_d   = state_q;
    oreg_d    = oreg_q;
    sreg_d    = sreg_q;
    case (state_q)
      ST_EMPTY: begin
        if (push_s) begin
          oreg_d  = code_s;
          state_d = ST_ONE;
        end else begin
          oreg_d  = '0;
        end
      end
      ST_ONE: begin
        if (push_s && pop_s) begin
          oreg_d  = code_s;
        end else if (push_s) begin
          sreg_d  = code_s;
          state_d = ST_TWO;
        end else if (pop_s) begin
          oreg_d  = '0;
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_TWO: begin
        if (pop_s) begin
          oreg_d  = sreg_q;
          sreg_d  = '0;
          state_d = ST_ONE;
        end else begin
          state_d = ST_TWO;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        oreg_d  = '0;
        sreg_d  = '0;
      end
    endcase
    // Set wins over clear because the new bit is OR-ed in after masking.
    pending_d   = (pending_q & ~bus.clr_mask) | (push_s ? hot_s : '0);
    err_d       = err_q | (acc_s & ~in_range_s);
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_TWO);
  end

  // State and output registers; all outputs come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      oreg_q      <= '0;
      sreg_q      <= '0;
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      oreg_q      <= oreg_d;
      sreg_q      <= sreg_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_code  = oreg_q;
  assign bus.pending   = pending_q;
  assign bus.err       = err_q;

endmodule
